// File: rtl/dcache_load_port_pkg.sv
// Shared definitions for the data-cache load port: FSM states, default
// geometry, derived address-field widths and the line record layout.
package dcache_load_port_pkg;

    localparam int DC_ADDR_W     = 32;
    localparam int DC_DATA_W     = 32;
    localparam int DC_LINES      = 16;
    localparam int DC_LINE_WORDS = 4;

    // Byte address = {tag, index, word select, 2'b00}
    localparam int DC_OFF_W  = $clog2(DC_LINE_WORDS * 4);
    localparam int DC_IDX_W  = $clog2(DC_LINES);
    localparam int DC_WSEL_W = $clog2(DC_LINE_WORDS);
    localparam int DC_TAG_W  = DC_ADDR_W - DC_OFF_W - DC_IDX_W;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MISS,
        ST_REQ,
        ST_FILL,
        ST_DONE,
        ST_FLUSH
    } dcache_state_e;

    // One cache line at the default geometry.
    typedef struct packed {
        logic                                       valid;
        logic [DC_TAG_W-1:0]                        tag;
        logic [DC_LINE_WORDS-1:0][DC_DATA_W-1:0]    words;
    } dcache_line_t;

endpackage

// File: rtl/dcache_tag_array.sv
// Valid/tag/data storage for a direct-mapped cache.
// Combinational read of one word plus its line's valid and tag; synchronous
// word writes during refill; a fill strobe that sets valid+tag; a per-index
// invalidate. Only the valid bits are reset, so reset empties the cache.
module dcache_tag_array #(
    parameter  int LINES      = 16,
    parameter  int LINE_WORDS = 4,
    parameter  int DATA_W     = 32,
    parameter  int TAG_W      = 24,
    localparam int IDX_W      = $clog2(LINES),
    localparam int WSEL_W     = $clog2(LINE_WORDS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [IDX_W-1:0]  rd_idx,
    input  logic [WSEL_W-1:0] rd_word,
    output logic              rd_valid,
    output logic [TAG_W-1:0]  rd_tag,
    output logic [DATA_W-1:0] rd_data,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [WSEL_W-1:0] wr_word,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              fill_en,
    input  logic [TAG_W-1:0]  fill_tag,
    input  logic              inv_en,
    input  logic [IDX_W-1:0]  inv_idx
);

    logic [LINES-1:0]                   valid_q;
    logic [TAG_W-1:0]                   tag_q  [LINES];
    logic [LINE_WORDS-1:0][DATA_W-1:0]  data_q [LINES];

    assign rd_valid = valid_q[rd_idx];
    assign rd_tag   = tag_q[rd_idx];
    assign rd_data  = data_q[rd_idx][rd_word];

    // Valid bits: cleared by reset, dropped by invalidate, set when a fill completes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= '0;
        end else begin
            if (inv_en)  valid_q[inv_idx] <= 1'b0;
            if (fill_en) valid_q[wr_idx]  <= 1'b1;
        end
    end

    // Tag and data payload; meaningless until the matching valid bit is set.
    always_ff @(posedge clk) begin
        if (fill_en) tag_q[wr_idx]           <= fill_tag;
        if (wr_en)   data_q[wr_idx][wr_word] <= wr_data;
    end

endmodule

// File: rtl/dcache_load_port.sv
// Load side of one data-cache port: direct-mapped, read-allocate, multi-word
// lines. Hits answer one cycle after acceptance; misses refill a whole line
// over a req/ack + beat protocol and answer from the refilled line.
// Optional feature macro: DCACHE_STATS_EN adds saturating hit/miss counters.
module dcache_load_port
    import dcache_load_port_pkg::*;
#(
    parameter int ADDR_W     = DC_ADDR_W,
    parameter int DATA_W     = DC_DATA_W,
    parameter int LINES      = DC_LINES,
    parameter int LINE_WORDS = DC_LINE_WORDS
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              ready,
    output logic              rdata_valid,
    output logic [DATA_W-1:0] rdata,
    output logic              data_missed,
    output logic              data_busy,
    output logic              data_finished,
    input  logic              flush_req,
    output logic              flushing,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]       hit_count,
    output logic [31:0]       miss_count
`endif
);

    localparam int OFF_W  = $clog2(LINE_WORDS * 4);
    localparam int IDX_W  = $clog2(LINES);
    localparam int WSEL_W = $clog2(LINE_WORDS);
    localparam int TAG_W  = ADDR_W - OFF_W - IDX_W;

    dcache_state_e      state, state_nxt;
    logic [ADDR_W-1:0]  lat_addr;
    logic [WSEL_W-1:0]  beat;
    logic [IDX_W-1:0]   flush_cnt;
    logic               flush_pend;
    logic [DATA_W-1:0]  rdata_q;
    logic               rdata_valid_q;

    logic [ADDR_W-1:0]  lookup_addr;
    logic               rd_valid;
    logic [TAG_W-1:0]   rd_tag;
    logic [DATA_W-1:0]  rd_data;
    logic               hit, accept, last_beat, in_miss;
    logic               unused_bits;

    // The single read port serves the IDLE lookup and the DONE answer.
    assign lookup_addr = (state == ST_IDLE) ? req_addr : lat_addr;
    assign hit         = rd_valid && (rd_tag == lookup_addr[ADDR_W-1 -: TAG_W]);
    assign accept      = (state == ST_IDLE) && req_valid && !flush_req;
    assign last_beat   = (state == ST_FILL) && mem_rvalid
                         && (beat == WSEL_W'(LINE_WORDS - 1));
    assign in_miss     = (state == ST_MISS) || (state == ST_REQ) || (state == ST_FILL);
    assign unused_bits = ^lookup_addr[1:0];

    dcache_tag_array #(
        .LINES      (LINES),
        .LINE_WORDS (LINE_WORDS),
        .DATA_W     (DATA_W),
        .TAG_W      (TAG_W)
    ) u_array (
        .clk      (clk),
        .reset    (reset),
        .rd_idx   (lookup_addr[OFF_W +: IDX_W]),
        .rd_word  (lookup_addr[2 +: WSEL_W]),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_data  (rd_data),
        .wr_en    ((state == ST_FILL) && mem_rvalid),
        .wr_idx   (lat_addr[OFF_W +: IDX_W]),
        .wr_word  (beat),
        .wr_data  (mem_rdata),
        .fill_en  (last_beat),
        .fill_tag (lat_addr[ADDR_W-1 -: TAG_W]),
        .inv_en   ((state == ST_MISS) || (state == ST_FLUSH)),
        .inv_idx  ((state == ST_FLUSH) ? flush_cnt : lat_addr[OFF_W +: IDX_W])
    );

    // Answer path: registered hit data, or the refilled word while in DONE.
    assign rdata_valid = rdata_valid_q || (state == ST_DONE);
    assign rdata       = (state == ST_DONE) ? rd_data : rdata_q;
    assign mem_addr    = {lat_addr[ADDR_W-1:OFF_W], OFF_W'(0)};

    // Next-state and state-decoded stall/handshake outputs.
    always_comb begin
        state_nxt     = state;
        // ready is forced low while reset is held so every output reads 0.
        ready         = (state == ST_IDLE) && reset;
        data_missed   = 1'b0;
        data_busy     = 1'b0;
        data_finished = 1'b0;
        flushing      = 1'b0;
        mem_req       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (flush_req)              state_nxt = ST_FLUSH;
                else if (req_valid && !hit) state_nxt = ST_MISS;
            end
            ST_MISS: begin
                data_missed = 1'b1;
                state_nxt   = ST_REQ;
            end
            ST_REQ: begin
                data_busy = 1'b1;
                mem_req   = 1'b1;
                if (mem_ack) state_nxt = ST_FILL;
            end
            ST_FILL: begin
                data_busy = 1'b1;
                if (last_beat) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                data_finished = 1'b1;
                state_nxt     = (flush_pend || flush_req) ? ST_FLUSH : ST_IDLE;
            end
            ST_FLUSH: begin
                flushing = 1'b1;
                if (flush_cnt == IDX_W'(LINES - 1)) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State, miss address, beat/flush counters, deferred flush and hit data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= ST_IDLE;
            lat_addr      <= '0;
            beat          <= '0;
            flush_cnt     <= '0;
            flush_pend    <= 1'b0;
            rdata_q       <= '0;
            rdata_valid_q <= 1'b0;
        end else begin
            state         <= state_nxt;
            rdata_valid_q <= accept && hit;
            if (accept && hit)  rdata_q  <= rd_data;
            if (accept && !hit) lat_addr <= req_addr;
            // Beat counter wraps back to 0 after the last beat of a line.
            if ((state == ST_FILL) && mem_rvalid) beat <= beat + 1'b1;
            if (state == ST_FLUSH) flush_cnt <= flush_cnt + 1'b1;
            // A flush seen mid-miss waits until the refill answers.
            flush_pend <= in_miss && (flush_pend || flush_req);
        end
    end

`ifdef DCACHE_STATS_EN
    // Saturating hit/miss counters over accepted requests; flush leaves them alone.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (accept) begin
            if (hit) begin
                if (hit_count != '1) hit_count <= hit_count + 32'd1;
            end else begin
                if (miss_count != '1) miss_count <= miss_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dcache_load_port.sv
// Scoreboard bench for dcache_load_port: stimulus pushes the expected answer
// of each load; a negedge monitor pops and checks whenever rdata_valid rises.
module tb_dcache_load_port;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic [31:0] req_addr = '0;
    logic        ready, rdata_valid, data_missed, data_busy, data_finished;
    logic [31:0] rdata;
    logic        flush_req = 1'b0;
    logic        flushing, mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;
`ifdef DCACHE_STATS_EN
    logic [31:0] hit_count, miss_count;
`endif

    dcache_load_port dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_addr      (req_addr),
        .ready         (ready),
        .rdata_valid   (rdata_valid),
        .rdata         (rdata),
        .data_missed   (data_missed),
        .data_busy     (data_busy),
        .data_finished (data_finished),
        .flush_req     (flush_req),
        .flushing      (flushing),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .mem_ack       (mem_ack),
        .mem_rvalid    (mem_rvalid),
        .mem_rdata     (mem_rdata)
`ifdef DCACHE_STATS_EN
        ,
        .hit_count     (hit_count),
        .miss_count    (miss_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        bit          miss;
        string       nm;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   miss_cyc = 0;
    bit   busy_seen = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Monitor: tracks stall pulses per transaction and checks each answer.
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            exp_q.delete();
            miss_cyc  = 0;
            busy_seen = 1'b0;
        end else begin
            if (data_missed) miss_cyc++;
            if (data_busy)   busy_seen = 1'b1;
            if (rdata_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_rdata_valid", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk({e.nm, "_rdata"},         rdata,                e.data);
                    chk({e.nm, "_finished"},      32'(data_finished),   32'(e.miss));
                    chk({e.nm, "_missed_cycles"}, 32'(miss_cyc),        e.miss ? 32'd1 : 32'd0);
                    chk({e.nm, "_busy_seen"},     32'(busy_seen),       32'(e.miss));
                    chk({e.nm, "_busy_at_answer"}, 32'(data_busy),      32'd0);
                end
                miss_cyc  = 0;
                busy_seen = 1'b0;
            end
        end
    end

    // Issue one load at a negedge once ready; expectation goes to the scoreboard.
    task automatic load(input string nm, input logic [31:0] a, input logic [31:0] exp, input bit miss);
        int t = 0;
        while (!ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk({nm, "_ready"}, 32'(ready), 32'd1);
        req_valid = 1'b1;
        req_addr  = a;
        exp_q.push_back('{exp, miss, nm});
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic hit_load(input string nm, input logic [31:0] a, input logic [31:0] exp);
        load(nm, a, exp, 1'b0);
        @(negedge clk);
        chk({nm, "_hit_latency"}, 32'(rdata_valid), 32'd1);
    endtask

    // Memory side of one refill; optional ack delay, flush pulse, early abort.
    task automatic refill(input string nm, input logic [31:0] line,
                          input logic [31:0] b0, input logic [31:0] b1,
                          input logic [31:0] b2, input logic [31:0] b3,
                          input int ack_dly, input int flush_beat, input int abort_at);
        logic [31:0] b [4];
        int t = 0;
        bit hold_ok = 1'b1;
        b[0] = b0; b[1] = b1; b[2] = b2; b[3] = b3;
        while (!mem_req && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk({nm, "_mem_req"},  32'(mem_req), 32'd1);
        chk({nm, "_mem_addr"}, mem_addr,     line);
        for (int i = 0; i < ack_dly; i++) begin
            @(negedge clk);
            if (!(mem_req && mem_addr == line && data_busy && !ready)) hold_ok = 1'b0;
        end
        if (ack_dly > 0) chk({nm, "_req_held_stalled"}, 32'(hold_ok), 32'd1);
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i == abort_at) begin
                mem_rvalid = 1'b0;
                return;
            end
            mem_rvalid = 1'b1;
            mem_rdata  = b[i];
            if (i == flush_beat) flush_req = 1'b1;
            @(negedge clk);
            flush_req = 1'b0;
        end
        mem_rvalid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        // Reset state
        repeat (2) @(negedge clk);
        chk("reset_outputs", {25'd0, ready, rdata_valid, data_missed, data_busy,
                              data_finished, flushing, mem_req}, 32'd0);
        chk("reset_rdata", rdata, 32'd0);
        @(posedge clk);
        #1 reset = 1'b1;

        // Case 1: cold miss
        load("c1_cold_100", 32'h100, 32'hAA, 1'b1);
        refill("c1", 32'h100, 32'hAA, 32'hBB, 32'hCC, 32'hDD, 0, -1, -1);
        // Case 2: hit on the same line
        hit_load("c2_hit_108", 32'h108, 32'hCC);
        // Case 3: conflicting tag at index 0
        load("c3_miss_500", 32'h500, 32'h11, 1'b1);
        refill("c3", 32'h500, 32'h11, 32'h22, 32'h33, 32'h44, 0, -1, -1);
        hit_load("c3_hit_504", 32'h504, 32'h22);
        // Case 4: 0x100 evicted, refill with delayed ack
        load("c4_remiss_10c", 32'h10C, 32'h1D, 1'b1);
        refill("c4", 32'h100, 32'h1A, 32'h1B, 32'h1C, 32'h1D, 5, -1, -1);
        hit_load("c4_hit_104", 32'h104, 32'h1B);

        // Case 5: flush during FILL is deferred until after the answer
        load("c5_miss_130", 32'h130, 32'h31, 1'b1);
        refill("c5", 32'h130, 32'h31, 32'h32, 32'h33, 32'h34, 0, 1, -1);
        n = 0;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if (flushing) n++;
            else if (n > 0) break;
        end
        chk("c5_flush_cycles", 32'(n), 32'd16);
        load("c5_reload_100", 32'h100, 32'h51, 1'b1);
        refill("c5r", 32'h100, 32'h51, 32'h52, 32'h53, 32'h54, 0, -1, -1);

        // Case 6: reset mid-FILL after two beats
        load("c6_miss_140", 32'h140, 32'h41, 1'b1);
        refill("c6", 32'h140, 32'h41, 32'h42, 32'h43, 32'h44, 0, -1, 2);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("c6_reset_outputs", {25'd0, ready, rdata_valid, data_missed, data_busy,
                                 data_finished, flushing, mem_req}, 32'd0);
        chk("c6_reset_mem_addr", mem_addr, 32'd0);
`ifdef DCACHE_STATS_EN
        chk("c6_reset_hit_count",  hit_count,  32'd0);
        chk("c6_reset_miss_count", miss_count, 32'd0);
`endif
        @(posedge clk);
        #1 reset = 1'b1;
        // Stray beats in IDLE must be ignored
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hDEAD;
        repeat (2) @(negedge clk);
        mem_rvalid = 1'b0;
        load("c6_reload_100", 32'h100, 32'h61, 1'b1);
        refill("c6r", 32'h100, 32'h61, 32'h62, 32'h63, 32'h64, 0, -1, -1);
        hit_load("c6_hit_10c", 32'h10C, 32'h64);
`ifdef DCACHE_STATS_EN
        chk("stats_hit_count",  hit_count,  32'd1);
        chk("stats_miss_count", miss_count, 32'd1);
`endif
        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
